// File: rtl/level_pkg.sv
// Shared level definitions and the saturate/wrap step function used by level_counter.
package level_pkg;

    localparam int unsigned LEVEL_W = 4;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_MAX = 4'd15;
    localparam level_t LEVEL_MIN = 4'd0;

    typedef enum logic [1:0] {
        CmdHold,
        CmdUp,
        CmdDown
    } cmd_e;

    // Next level for a command; at the limits either hold or wrap to the other end.
    function automatic level_t level_step(input level_t cur, input cmd_e cmd, input logic wrap);
        level_t nxt;
        nxt = cur;
        case (cmd)
            CmdUp: begin
                if (cur == LEVEL_MAX) begin
                    nxt = wrap ? LEVEL_MIN : cur;
                end else begin
                    nxt = cur + level_t'(1);
                end
            end
            CmdDown: begin
                if (cur == LEVEL_MIN) begin
                    nxt = wrap ? LEVEL_MAX : cur;
                end else begin
                    nxt = cur - level_t'(1);
                end
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/level_counter_btn_debounce.sv
// One push-button path: two-flop synchroniser, stability-count debouncer and
// a registered one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // The D-th consecutive differing sample flips the state, so the count tops out at D-1.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = ~deb_q;
                press_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/level_counter.sv
// Two debounced push-buttons step a registered 4-bit level up/down, saturating
// or wrapping at 0/15, with registered limit flags and a change pulse.
module level_counter
    import level_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          WRAP            = 1'b0,
    parameter level_t      RESET_VALUE     = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [LEVEL_W-1:0] counter,
    output logic               at_max,
    output logic               at_min,
    output logic               step
);

    logic   up_press, down_press;
    cmd_e   cmd;
    level_t level_q, level_d;
    logic   step_q, step_d;
    logic   at_max_q, at_max_d;
    logic   at_min_q, at_min_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_up),
        .press(up_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_down (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_down),
        .press(down_press)
    );

    // Presses on both buttons in the same cycle cancel out.
    always_comb begin
        cmd = CmdHold;
        if (up_press && !down_press) begin
            cmd = CmdUp;
        end else if (down_press && !up_press) begin
            cmd = CmdDown;
        end
    end

    always_comb begin
        level_d  = level_step(level_q, cmd, WRAP);
        step_d   = (level_d != level_q);
        at_max_d = (level_d == LEVEL_MAX);
        at_min_d = (level_d == LEVEL_MIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= RESET_VALUE;
            step_q   <= 1'b0;
            at_max_q <= (RESET_VALUE == LEVEL_MAX);
            at_min_q <= (RESET_VALUE == LEVEL_MIN);
        end else begin
            level_q  <= level_d;
            step_q   <= step_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign counter = level_q;
    assign step    = step_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;

endmodule

// File: tb/tb_level_counter.sv
// Directed bench: saturating, wrapping and RESET_VALUE=3 instances share the buttons.
module tb_level_counter;

    logic       clk = 1'b0;
    logic       rst, rst_r;
    logic       btn_up, btn_down;
    logic [3:0] cnt_a, cnt_w, cnt_r;
    logic       max_a, min_a, step_a;
    logic       max_w, min_w, step_w;
    logic       max_r, min_r, step_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    level_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0), .RESET_VALUE(4'd0)) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .counter(cnt_a), .at_max(max_a), .at_min(min_a), .step(step_a)
    );

    level_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b1), .RESET_VALUE(4'd0)) dut_w (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .counter(cnt_w), .at_max(max_w), .at_min(min_w), .step(step_w)
    );

    level_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0), .RESET_VALUE(4'd3)) dut_r (
        .clk(clk), .rst(rst_r), .btn_up(btn_up), .btn_down(btn_down),
        .counter(cnt_r), .at_max(max_r), .at_min(min_r), .step(step_r)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the buttons and stop right after the edge where the level updates.
    task automatic press_start(input logic up, input logic down);
        btn_up   = up;
        btn_down = down;
        wait_neg(7);
    endtask

    task automatic press_end();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_neg(7);
    endtask

    initial begin
        rst      = 1'b1;
        rst_r    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_neg(2);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_min_a", min_a, 1);
        check("rst_max_a", max_a, 0);
        check("rst_step_a", step_a, 0);
        check("rst_cnt_r", cnt_r, 3);
        check("rst_min_r", min_r, 0);
        check("rst_max_r", max_r, 0);
        rst   = 1'b0;
        rst_r = 1'b0;
        wait_neg(2);

        // Clean press: update lands on edge 7.
        btn_up = 1'b1;
        wait_neg(6);
        check("clean_pre_cnt", cnt_a, 0);
        check("clean_pre_step", step_a, 0);
        wait_neg(1);
        check("clean_cnt", cnt_a, 1);
        check("clean_step", step_a, 1);
        check("clean_min", min_a, 0);
        wait_neg(1);
        check("clean_step_drop", step_a, 0);
        wait_neg(12);
        btn_up = 1'b0;
        wait_neg(8);
        check("release_cnt", cnt_a, 1);
        check("release_step", step_a, 0);

        // Bounce: only the final rise counts.
        for (int k = 0; k < 3; k++) begin
            btn_up = 1'b1;
            wait_neg(2);
            btn_up = 1'b0;
            wait_neg(2);
        end
        btn_up = 1'b1;
        wait_neg(6);
        check("bounce_pre_cnt", cnt_a, 1);
        wait_neg(1);
        check("bounce_cnt", cnt_a, 2);
        check("bounce_step", step_a, 1);
        btn_up = 1'b0;
        wait_neg(8);

        // Return A and W to 0.
        rst = 1'b1;
        #1;
        check("rst2_cnt_a", cnt_a, 0);
        check("rst2_cnt_w", cnt_w, 0);
        check("rst2_min_w", min_w, 1);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(2);

        // Saturation on A, wrap on W.
        for (int i = 0; i < 16; i++) begin
            press_start(1'b1, 1'b0);
            check("sat_up_cnt", cnt_a, (i < 15) ? i + 1 : 15);
            check("sat_up_step", step_a, (i < 15) ? 1 : 0);
            check("wrap_up_cnt", cnt_w, (i + 1) % 16);
            check("wrap_up_step", step_w, 1);
            if (i == 14) begin
                check("sat_max_a", max_a, 1);
                check("sat_min_a", min_a, 0);
            end
            press_end();
        end
        check("wrap_min_w", min_w, 1);
        check("wrap_max_w", max_w, 0);
        for (int i = 0; i < 16; i++) begin
            press_start(1'b0, 1'b1);
            check("sat_dn_cnt", cnt_a, (i < 15) ? 14 - i : 0);
            check("sat_dn_step", step_a, (i < 15) ? 1 : 0);
            check("wrap_dn_cnt", cnt_w, 15 - i);
            check("wrap_dn_step", step_w, 1);
            if (i == 0) check("wrap_dn_max_w", max_w, 1);
            press_end();
        end
        check("sat_min_end", min_a, 1);
        check("sat_max_end", max_a, 0);

        // Simultaneous presses cancel.
        for (int i = 0; i < 5; i++) begin
            press_start(1'b1, 1'b0);
            press_end();
        end
        check("five_cnt", cnt_a, 5);
        press_start(1'b1, 1'b1);
        check("simul_cnt", cnt_a, 5);
        check("simul_step", step_a, 0);
        check("simul_cnt_w", cnt_w, 5);
        press_end();
        press_start(1'b0, 1'b1);
        check("lone_dn_cnt", cnt_a, 4);
        check("lone_dn_step", step_a, 1);
        press_end();

        // R tracked every press from 3: 5 after scenarios 1-2, saturate, down to 0, +5, -1.
        check("r_pre_cnt", cnt_r, 4);
        btn_up = 1'b1;
        wait_neg(5);
        rst_r = 1'b1;
        #1;
        check("midrst_cnt", cnt_r, 3);
        check("midrst_step", step_r, 0);
        check("midrst_min", min_r, 0);
        check("midrst_max", max_r, 0);
        wait_neg(1);
        rst_r = 1'b0;
        wait_neg(6);
        check("midrst_pre_cnt", cnt_r, 3);
        wait_neg(1);
        check("midrst_post_cnt", cnt_r, 4);
        check("midrst_post_step", step_r, 1);
        btn_up = 1'b0;
        wait_neg(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/level_counter.md
# level_counter

Front-end stage that produces the 4-bit `counter` value consumed by the thermometer encoder. It turns two raw push-buttons (`btn_up`, `btn_down`) into a clean 4-bit level. Each button is synchronised, debounced and edge-detected, and each press steps the level by one. The level saturates at 0/15 by default, or wraps when configured.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level flips. The board build sets 1_000_000. Legal range is ≥1.
- `WRAP`, default 0: 0 saturates at 0 and 15; 1 wraps 15→0 and 0→15.
- `RESET_VALUE`, default 0: level loaded on reset, 0..15.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_up` input 1: raw asynchronous up button, active-high, may bounce.
- `btn_down` input 1: raw asynchronous down button, active-high, may bounce.
- `counter` output 4: current level, registered. Feeds the thermometer encoder directly.
- `at_max` output 1: registered, 1 when `counter`==15.
- `at_min` output 1: registered, 1 when `counter`==0.
- `step` output 1: one-cycle pulse, registered, asserted in the cycle `counter` changes value.

## Operation
- **Per-button path:**
  - Two-flop synchroniser.
  - Stability counter plus debounced-state register (reset 0).
  - Each edge where the synchronised sample differs from the debounced state increments the stability counter.
  - Any edge where they are equal clears the counter to 0.
  - When the counter has seen `DEBOUNCE_CYCLES` consecutive differing samples, the debounced state flips and the counter clears.
- **Press detection:** a press is a 0→1 transition of the debounced state. Release (1→0) has no effect on the level.
- **Level update, evaluated each edge:**
  - up press only: `counter`+1 if below 15. At 15 it goes to 0 if `WRAP`, otherwise it holds.
  - down press only: `counter`−1 if above 0. At 0 it goes to 15 if `WRAP`, otherwise it holds.
  - both presses in the same cycle: no change, `step`=0.
  - no press: hold.
- **Outputs on update:** `step`=1 only when the value actually changes, so a press against saturation gives `step`=0. `at_max`/`at_min` are updated in the same edge as `counter`.
- **Stability counter width:** `$clog2(DEBOUNCE_CYCLES+1)` bits. It never exceeds `DEBOUNCE_CYCLES`.
- **Reset values:**
  - `counter`=`RESET_VALUE`.
  - `at_max`=(`RESET_VALUE`==15); `at_min`=(`RESET_VALUE`==0).
  - `step`=0.
  - Synchronisers, stability counters and debounced states all 0.
- **Reset mid-operation:** all in-flight debounce progress is discarded. A button still held when `rst` deasserts is treated as a fresh press after a full debounce period.

## Timing
- **Press latency:** raw level change first sampled at edge 1 → sync stage 2 valid at edge 2 → debounced state flips at edge 2+`DEBOUNCE_CYCLES` → `counter`, `step`, `at_*` update at edge 3+`DEBOUNCE_CYCLES`. With the default this is edge 7.
- **`step` width:** high for exactly one cycle per change.
- **Bounce:** a bounce that returns to the debounced value for a single sample restarts the full `DEBOUNCE_CYCLES` window.
- **Minimum spacing:** presses on one button are spaced by at least 2×`DEBOUNCE_CYCLES` cycles (press plus release). This is inherent; there is no extra hold-off.
- **Combined latency:** end-to-end latency to the thermometer output is this block's latency plus one register.

## Structure
- **Shared package `level_pkg`:**
  - `LEVEL_W`=4.
  - `LEVEL_MAX`=4'd15.
  - `LEVEL_MIN`=4'd0.
- **Sub-module `btn_debounce`:** synchroniser, stability counter, debounced state and rising-edge pulse output. It is instantiated twice, parameterised by `DEBOUNCE_CYCLES`.
- **Top:** holds the level register, saturation/wrap logic and flag registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Clean press:** reset, then `btn_up` held high 20 cycles. → `counter` 0→1 at edge 7; `step`=1 for exactly that cycle; `at_min` 1→0. Release gives no further change.
2. **Bounce:** `btn_up` toggles every 2 cycles for 12 cycles, then is held high. → exactly one increment, occurring 7 edges after the last 0→1 transition of `btn_up`.
3. **Saturation:** 16 clean up presses from 0. → `counter`=15 after 15 presses with `at_max`=1. The 16th press leaves 15 with `step`=0. Then 16 down presses → 0, `at_min`=1.
4. **Wrap (`WRAP`=1):** at 15, up press → 0 with `step`=1. At 0, down press → 15.
5. **Simultaneous:** `counter`=5, `btn_up` and `btn_down` rise on the same edge. → no change, `step`=0. A subsequent lone down press gives 4.
6. **Reset mid-operation:** `RESET_VALUE`=3. Assert `rst` at debounce edge 4 of an up press, deassert next cycle, keep `btn_up` held. → `counter`=3 immediately on `rst` with `step`=0 and `at_min`=`at_max`=0. After release of reset, `counter`=4 at edge 7 from the first post-reset sampling edge.
